// File: rtl/mem_fifo_if.sv
// Producer/consumer handshake bundle for mem_fifo: enqueue/dequeue requests,
// read data and the registered status flags.
interface mem_fifo_if #(
  parameter int DATA_WIDTH = 6,
  parameter int ADDR_WIDTH = 3
);
  logic                  push;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  pop;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  valid_out;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   count;
  logic                  err;

  // Side that issues push/pop requests and observes the queue.
  modport master (
    output push, data_in, pop,
    input  data_out, valid_out, full, empty, almost_full, almost_empty, count, err
  );

  // The FIFO itself.
  modport slave (
    input  push, data_in, pop,
    output data_out, valid_out, full, empty, almost_full, almost_empty, count, err
  );
endinterface

// File: rtl/mem_fifo.sv
// Synchronous FIFO on a 2^ADDR_WIDTH-entry register memory. Wrap-around
// pointers, occupancy counter, registered full/empty/almost flags and a
// one-cycle err pulse on overflow or underflow attempts.
module mem_fifo #(
  parameter int DATA_WIDTH = 6,
  parameter int ADDR_WIDTH = 3,
  parameter int AF_LEVEL   = 6,
  parameter int AE_LEVEL   = 2
) (
  input  logic        clk,
  input  logic        RESET_L,
  mem_fifo_if.slave   bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH+1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH+1)'(AE_LEVEL);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [ADDR_WIDTH:0]   count_q, count_nxt;
  logic [DATA_WIDTH-1:0] data_out_q;
  logic                  valid_q, err_q;
  logic                  full_q, empty_q, af_q, ae_q;
  logic                  push_acc, pop_acc, overflow, underflow;

  // Acceptance decisions from the registered flags; a pop at full frees the
  // slot the simultaneous push needs, but an empty queue never bypasses.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    pop_acc   = 1'b0;
    push_acc  = 1'b0;
    overflow  = 1'b0;
    underflow = 1'b0;
    count_nxt = count_q;
    pop_acc   = bus.pop & ~empty_q;
    push_acc  = bus.push & (~full_q | pop_acc);
    overflow  = bus.push & full_q & ~bus.pop;
    underflow = bus.pop & empty_q;
    count_nxt = count_q + (ADDR_WIDTH+1)'(push_acc) - (ADDR_WIDTH+1)'(pop_acc);
  end

  // Storage write port; the reset cycle's requests are ignored.
  // NOTE: the memory array has no reset; queued words become unreachable once
  // the pointers and count are cleared, so clearing the array buys nothing.
  always_ff @(posedge clk) begin
    if (RESET_L && push_acc) mem[wr_ptr] <= bus.data_in;
  end

  // Pointers, read data, occupancy, flags and error pulse.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!RESET_L) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      af_q       <= 1'b0;
      ae_q       <= 1'b1;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (pop_acc) begin
        rd_ptr     <= rd_ptr + ADDR_WIDTH'(1);
        data_out_q <= mem[rd_ptr];
      end
      valid_q <= pop_acc;
      err_q   <= overflow | underflow;
      count_q <= count_nxt;
      full_q  <= (count_nxt == DEPTH_C);
      empty_q <= (count_nxt == '0);
      af_q    <= (count_nxt >= AF_C);
      ae_q    <= (count_nxt <= AE_C);
    end
  end

  assign bus.data_out     = data_out_q;
  assign bus.valid_out    = valid_q;
  assign bus.count        = count_q;
  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.almost_full  = af_q;
  assign bus.almost_empty = ae_q;
  assign bus.err          = err_q;
endmodule

// File: tb/tb_mem_fifo.sv
// Self-checking bench for mem_fifo: a queue-based model checked every cycle,
// directed scenarios with literal expectations, and a randomized phase.
module tb_mem_fifo;
  localparam int DW    = 6;
  localparam int AW    = 3;
  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 2;

  logic clk = 1'b0;
  logic rst_l = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  mem_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  mem_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
    .clk     (clk),
    .RESET_L (rst_l),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a queue of words plus the last popped word.
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_dout = '0;
  bit            m_valid = 1'b0;
  bit            m_err = 1'b0;
  bit            live = 1'b0;

  initial begin
    forever begin
      @(posedge clk);
      if (!rst_l) begin
        q.delete();
        m_dout  = '0;
        m_valid = 1'b0;
        m_err   = 1'b0;
        live    = 1'b1;
      end else begin
        bit can_pop, can_push;
        can_pop  = bus.pop && q.size() > 0;
        can_push = bus.push && (q.size() < DEPTH || can_pop);
        m_err    = (bus.pop && q.size() == 0) || (bus.push && q.size() == DEPTH && !bus.pop);
        m_valid  = can_pop;
        if (can_pop) m_dout = q.pop_front();
        if (can_push) q.push_back(bus.data_in);
      end
      #1;
      if (live) begin
        check("m_count", 32'(bus.count), q.size());
        check("m_full", 32'(bus.full), 32'(q.size() == DEPTH));
        check("m_empty", 32'(bus.empty), 32'(q.size() == 0));
        check("m_af", 32'(bus.almost_full), 32'(q.size() >= AF));
        check("m_ae", 32'(bus.almost_empty), 32'(q.size() <= AE));
        check("m_valid", 32'(bus.valid_out), 32'(m_valid));
        check("m_dout", 32'(bus.data_out), 32'(m_dout));
        check("m_err", 32'(bus.err), 32'(m_err));
      end
    end
  end

  // Apply one cycle of inputs; returns on the following falling edge.
  task automatic drive(input bit ps, input bit pp, input logic [DW-1:0] d, input bit rl);
    bus.push    = ps;
    bus.pop     = pp;
    bus.data_in = d;
    rst_l       = rl;
    @(negedge clk);
  endtask

  initial begin
    logic [DW-1:0] exp_seq [8];
    bus.push = 1'b0;
    bus.pop = 1'b0;
    bus.data_in = '0;

    // Reset held two cycles with requests active.
    drive(1, 1, 6'h3F, 0);
    drive(1, 1, 6'h3F, 0);
    check("rst_count", 32'(bus.count), 0);
    check("rst_empty", 32'(bus.empty), 1);
    check("rst_ae", 32'(bus.almost_empty), 1);
    check("rst_valid", 32'(bus.valid_out), 0);
    check("rst_err", 32'(bus.err), 0);
    check("rst_dout", 32'(bus.data_out), 0);

    // Fill with 0x01..0x08.
    for (int i = 1; i <= 8; i++) begin
      drive(1, 0, DW'(i), 1);
      check("fill_af", 32'(bus.almost_full), 32'(i >= 6));
    end
    check("fill_full", 32'(bus.full), 1);
    check("fill_count", 32'(bus.count), 8);

    // Drain in order.
    for (int i = 1; i <= 8; i++) begin
      drive(0, 1, '0, 1);
      check("drain_dout", 32'(bus.data_out), i);
      check("drain_valid", 32'(bus.valid_out), 1);
    end
    check("drain_empty", 32'(bus.empty), 1);

    // Underflow at empty.
    drive(0, 1, '0, 1);
    check("uf_err", 32'(bus.err), 1);
    check("uf_valid", 32'(bus.valid_out), 0);
    drive(0, 0, '0, 1);
    check("uf_err_fall", 32'(bus.err), 0);

    // Refill, overflow, then simultaneous push+pop at full.
    for (int i = 1; i <= 8; i++) drive(1, 0, DW'(i), 1);
    drive(1, 0, 6'h3F, 1);
    check("of_err", 32'(bus.err), 1);
    check("of_count", 32'(bus.count), 8);
    drive(1, 1, 6'h2A, 1);
    check("fullpp_count", 32'(bus.count), 8);
    check("fullpp_err", 32'(bus.err), 0);
    check("fullpp_dout", 32'(bus.data_out), 1);
    exp_seq = '{6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07, 6'h08, 6'h2A};
    for (int i = 0; i < 8; i++) begin
      drive(0, 1, '0, 1);
      check("fullpp_drain", 32'(bus.data_out), 32'(exp_seq[i]));
    end

    // Push+pop at empty: push only, err pulses.
    drive(1, 1, 6'h15, 1);
    check("emptypp_count", 32'(bus.count), 1);
    check("emptypp_err", 32'(bus.err), 1);
    check("emptypp_valid", 32'(bus.valid_out), 0);
    drive(0, 1, '0, 1);
    check("emptypp_dout", 32'(bus.data_out), 6'h15);

    // Wrap-around: keep occupancy within 3..5 for 20 cycles.
    for (int i = 0; i < 4; i++) drive(1, 0, DW'($urandom), 1);
    for (int i = 0; i < 20; i++) begin
      int s;
      bit ps, pp;
      s  = q.size();
      ps = (s <= 3) ? 1'b1 : (s >= 5) ? 1'b0 : 1'($urandom);
      pp = (s >= 5) ? 1'b1 : (s <= 3) ? 1'($urandom) : 1'($urandom);
      if (s <= 3) ps = 1'b1;
      drive(ps, pp, DW'($urandom), 1);
    end

    // Randomized traffic with occasional reset.
    for (int i = 0; i < 400; i++)
      drive($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 50, DW'($urandom),
            $urandom_range(0, 63) != 0);

    // Reset mid-operation at count 5.
    drive(0, 0, '0, 0);
    for (int i = 0; i < 5; i++) drive(1, 0, DW'(i + 3), 1);
    check("mid_pre_count", 32'(bus.count), 5);
    drive(1, 1, 6'h22, 0);
    check("mid_count", 32'(bus.count), 0);
    check("mid_empty", 32'(bus.empty), 1);
    drive(1, 0, 6'h11, 1);
    drive(0, 1, '0, 1);
    check("mid_dout", 32'(bus.data_out), 6'h11);
    check("mid_valid", 32'(bus.valid_out), 1);
    drive(0, 0, '0, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/mem_fifo.md
# mem_fifo

Parametrised synchronous FIFO built on a 2^ADDR_WIDTH-entry register memory; the next generation of the team's addressed read/write memory block. The producer/consumer no longer drives explicit addresses: internal wrap-around pointers, occupancy counting, full/empty and programmable almost-full/almost-empty flags are added. Overflow and underflow are reported on `err`. It sits between a data producer and consumer in the same clock domain and replaces direct `mem` instantiation where queueing is needed.

## Interface
- DATA_WIDTH, 6, width of each stored word
- ADDR_WIDTH, 3, pointer width; DEPTH = 2^ADDR_WIDTH entries
- AF_LEVEL, 6, almost_full asserted when count >= AF_LEVEL (1..DEPTH)
- AE_LEVEL, 2, almost_empty asserted when count <= AE_LEVEL (0..DEPTH-1)

- clk  in  1  single clock; all state updates on its rising edge
- RESET_L  in  1  synchronous, active-low reset
- push  in  1  write request; data_in stored when accepted
- data_in  in  DATA_WIDTH  word to enqueue
- pop  in  1  read request; head word presented on data_out when accepted
- data_out  out  DATA_WIDTH  registered read data
- valid_out  out  1  data_out holds a newly popped word this cycle
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count >= AF_LEVEL
- almost_empty  out  1  count <= AE_LEVEL
- count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH
- err  out  1  one-cycle pulse on overflow or underflow attempt

## Operation
- Reset (RESET_L low at rising edge): write/read pointers = 0, count = 0, data_out = 0, valid_out = 0, err = 0, full = 0, empty = 1, almost_full = 0, almost_empty = 1. Memory contents are not cleared but become unreachable. Reset mid-operation discards all queued data; requests in the reset cycle are ignored.
- Push accepted when push=1 and (full=0 or pop accepted in the same cycle): mem[wr_ptr] <= data_in, wr_ptr += 1 modulo DEPTH.
- Pop accepted when pop=1 and empty=0: data_out <= mem[rd_ptr], valid_out <= 1, rd_ptr += 1 modulo DEPTH. Otherwise valid_out <= 0 and data_out holds its last value.
- Pointers wrap from DEPTH-1 to 0 with no gap; full/empty are derived from count, not pointer equality.
- count next = count + push_acc - pop_acc; never outside 0..DEPTH.
- Simultaneous push and pop:
  - not empty, not full: both accepted, count unchanged.
  - full: both accepted (the pop frees the slot), count stays DEPTH, err = 0.
  - empty: push accepted, pop rejected (no write-through bypass), err pulses, count becomes 1.
- Overflow: push=1, full=1, pop=0 -> data dropped, state unchanged, err = 1 for the next cycle.
- Underflow: pop=1, empty=1 -> no read, valid_out = 0, err = 1 for the next cycle.
- err is registered; it is high exactly one cycle per offending request and falls unless another offending request occurs.
- All flags and count are registered and reflect state after the current edge's update.

## Timing
- Pop latency: data_out/valid_out valid one cycle after the edge at which pop was sampled.
- Push-to-visible: a word pushed at edge N is poppable at edge N+1 (empty falls after edge N).
- Flags, count and err update on the same edge as the triggering push/pop.
- Back-to-back pushes and pops every cycle are sustained; throughput is one word per cycle in each direction.
- No combinational path from push/pop/data_in to any output.

## Test plan
- Reset: hold RESET_L=0 for 2 cycles with push=pop=1 -> count=0, empty=1, almost_empty=1, valid_out=0, err=0, data_out=0.
- Fill/drain: push 0x01..0x08 on 8 consecutive cycles -> full=1 and count=8 after the 8th edge, almost_full from count=6. Pop 8 times -> data_out 0x01..0x08 in order, valid_out high 8 cycles, empty=1 at the end.
- Overflow/underflow: at full, push 0x3F -> err one-cycle pulse, count stays 8, 0x3F never appears on data_out. At empty, pop -> err pulse, valid_out=0.
- Simultaneous: at count=8, push 0x2A + pop -> count 8, err=0, 0x2A emerges last. At empty, push 0x15 + pop -> count 1, err pulse, next pop returns 0x15.
- Wrap-around: 20 cycles of interleaved push/pop with count kept between 3 and 5 -> sequence preserved across pointer wrap, flags track thresholds (almost_empty at count<=2).
- Reset mid-operation: at count=5, assert RESET_L=0 for one cycle -> count=0, empty=1; a subsequent push 0x11/pop returns 0x11.
